// File: rtl/note_key_scheduler.sv
// note_key_scheduler: resolves held piano keys (PS/2 make codes) into one
// active note by last-pressed priority, with an optional press/release queue.
// Build option: define KEY_EVENT_FIFO_EN to build the event FIFO; otherwise
// ev_valid/ev_data/ev_overflow are tied low and ev_ready is ignored.
// Ports: clk, rst (sync, active-high); key_valid/key_code/key_break scan in;
// note/note_change/held_mask to the tone generator;
// ev_valid/ev_data/ev_ready/ev_overflow event stream to the game logic.
module note_key_scheduler #(
   parameter int STACK_DEPTH = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   input  logic        key_break,
   output logic [3:0]  note,
   output logic        note_change,
   output logic [11:0] held_mask,
   output logic        ev_valid,
   output logic [4:0]  ev_data,
   input  logic        ev_ready,
   output logic        ev_overflow
);

   localparam int CW = $clog2(STACK_DEPTH + 1);

   logic [3:0]    code_note;
   logic [11:0]   note_bit;
   logic          is_held;
   logic          do_press;
   logic          do_release;
   logic [3:0]    stk_q [STACK_DEPTH];
   logic [3:0]    stk_d [STACK_DEPTH];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [3:0]    note_d;
   logic          found;
   logic          ev_push;
   logic [4:0]    ev_push_data;

   always_comb begin
      unique case (key_code)
         8'h15:   code_note = 4'd12;
         8'h1D:   code_note = 4'd11;
         8'h24:   code_note = 4'd10;
         8'h2D:   code_note = 4'd9;
         8'h2C:   code_note = 4'd8;
         8'h35:   code_note = 4'd7;
         8'h3C:   code_note = 4'd6;
         8'h43:   code_note = 4'd5;
         8'h44:   code_note = 4'd4;
         8'h4D:   code_note = 4'd3;
         8'h54:   code_note = 4'd2;
         8'h5B:   code_note = 4'd1;
         default: code_note = 4'd0;
      endcase
   end

   assign note_bit = (code_note == 4'd0) ? 12'd0
                   : (12'd1 << (code_note - 4'd1));

   assign is_held    = |(held_mask & note_bit);
   assign do_press   = key_valid && !key_break
                    && (code_note != 4'd0) && !is_held;
   assign do_release = key_valid && key_break && is_held;

   // Stack: entry 0 is the oldest, entry cnt-1 the top.
   // Slots at or above cnt are kept at zero.
   always_comb begin
      stk_d = stk_q;
      cnt_d = cnt_q;
      found = 1'b0;
      if (do_press) begin
         if (cnt_q == CW'(STACK_DEPTH)) begin
            // Full: the oldest entry falls off the bottom.
            for (int i = 0; i < STACK_DEPTH - 1; i++)
               stk_d[i] = stk_q[i+1];
            stk_d[STACK_DEPTH-1] = code_note;
         end else begin
            for (int i = 0; i < STACK_DEPTH; i++)
               if (CW'(i) == cnt_q)
                  stk_d[i] = code_note;
            cnt_d = cnt_q + CW'(1);
         end
      end else if (do_release) begin
         // Close the gap left by the released note.
         for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            if (stk_q[i] == code_note && CW'(i) < cnt_q)
               found = 1'b1;
            if (found)
               stk_d[i] = stk_q[i+1];
         end
         if (stk_q[STACK_DEPTH-1] == code_note
             && cnt_q == CW'(STACK_DEPTH))
            found = 1'b1;
         if (found) begin
            stk_d[STACK_DEPTH-1] = 4'd0;
            cnt_d = cnt_q - CW'(1);
         end
      end
      note_d = 4'd0;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (CW'(i) < cnt_d)
            note_d = stk_d[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_mask   <= 12'd0;
         cnt_q       <= '0;
         note        <= 4'd0;
         note_change <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++)
            stk_q[i] <= 4'd0;
      end else begin
         if (do_press)
            held_mask <= held_mask | note_bit;
         else if (do_release)
            held_mask <= held_mask & ~note_bit;
         stk_q       <= stk_d;
         cnt_q       <= cnt_d;
         note        <= note_d;
         note_change <= (note_d != note);
      end
   end

   assign ev_push      = do_press | do_release;
   assign ev_push_data = {do_press, code_note};

`ifdef KEY_EVENT_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

   logic [4:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;
   logic          full;
   logic          pop;
   logic          wr_en;

   assign ev_valid = (occ != '0);
   assign full     = (occ == FULL_OCC);
   assign pop      = ev_valid && ev_ready;
   // A pop frees the slot in the same cycle, so full+pop still accepts.
   assign wr_en    = ev_push && (!full || pop);
   assign ev_data  = ev_valid ? mem[rd_ptr] : 5'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         ev_overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= ev_push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)
            occ <= occ + (AW+1)'(1);
         else if (!wr_en && pop)
            occ <= occ - (AW+1)'(1);
         if (ev_push && !wr_en)
            ev_overflow <= 1'b1;
      end
   end
`else
   logic unused_fifo;

   assign ev_valid    = 1'b0;
   assign ev_data     = 5'd0;
   assign ev_overflow = 1'b0;
   assign unused_fifo = ^{ev_ready, ev_push, ev_push_data,
                          (FIFO_DEPTH != 0)};
`endif

endmodule

// File: tb/tb_note_key_scheduler.sv
// tb_note_key_scheduler: directed + randomized bench for note_key_scheduler
// against a queue-based reference model of held keys, note stack and FIFO.
`timescale 1ns/1ps
module tb_note_key_scheduler;

   localparam int SD = 4;
   localparam int FD = 4;
`ifdef KEY_EVENT_FIFO_EN
   localparam bit FIFO_ON = 1'b1;
`else
   localparam bit FIFO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'd0;
   logic        key_break = 1'b0;
   logic        ev_ready = 1'b0;
   logic [3:0]  note;
   logic        note_change;
   logic [11:0] held_mask;
   logic        ev_valid;
   logic [4:0]  ev_data;
   logic        ev_overflow;

   note_key_scheduler #(.STACK_DEPTH(SD), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
      .note(note), .note_change(note_change), .held_mask(held_mask),
      .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
      .ev_overflow(ev_overflow)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Scan code of note n (1..12).
   logic [7:0] code_tab [1:12] = '{8'h5B, 8'h54, 8'h4D, 8'h44, 8'h43,
      8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15};

   function automatic int map_code(input logic [7:0] c);
      for (int n = 1; n <= 12; n++)
         if (code_tab[n] == c) return n;
      return 0;
   endfunction

   logic [11:0] m_mask = 12'd0;
   int          m_stk[$];
   logic [4:0]  m_fifo[$];
   bit          m_ovf = 1'b0;
   logic [3:0]  m_note = 4'd0;
   bit          m_chg = 1'b0;
   bit          armed = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_mask = 12'd0;
         m_stk.delete();
         m_fifo.delete();
         m_ovf  = 1'b0;
         m_note = 4'd0;
         m_chg  = 1'b0;
         armed  = 1'b1;
      end else if (armed) begin
         int n;
         bit ev;
         logic [4:0] ed;
         logic [3:0] prev;
         n = map_code(key_code);
         ev = 1'b0;
         ed = 5'd0;
         prev = m_note;
         if (key_valid && n != 0) begin
            if (!key_break && !m_mask[n-1]) begin
               m_mask[n-1] = 1'b1;
               m_stk.push_back(n);
               if (m_stk.size() > SD) m_stk.delete(0);
               ev = 1'b1;
               ed = {1'b1, 4'(n)};
            end else if (key_break && m_mask[n-1]) begin
               m_mask[n-1] = 1'b0;
               for (int i = 0; i < m_stk.size(); i++)
                  if (m_stk[i] == n) begin
                     m_stk.delete(i);
                     break;
                  end
               ev = 1'b1;
               ed = {1'b0, 4'(n)};
            end
         end
         if (FIFO_ON) begin
            if (ev_ready && m_fifo.size() > 0) m_fifo.delete(0);
            if (ev) begin
               if (m_fifo.size() < FD) m_fifo.push_back(ed);
               else m_ovf = 1'b1;
            end
         end
         m_note = (m_stk.size() > 0) ? 4'(m_stk[$]) : 4'd0;
         m_chg  = (m_note != prev);
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         logic [4:0] eh;
         eh = (m_fifo.size() > 0) ? m_fifo[0] : 5'd0;
         chk("note", note, m_note);
         chk("note_change", note_change, m_chg);
         chk("held_mask", held_mask, m_mask);
         chk("ev_valid", ev_valid, m_fifo.size() > 0);
         chk("ev_data", ev_data, eh);
         chk("ev_overflow", ev_overflow, m_ovf);
      end
   end

   task automatic step(input bit kv, input logic [7:0] code,
                       input bit brk, input bit rdy);
      key_valid = kv;
      key_code  = code;
      key_break = brk;
      ev_ready  = rdy;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      ev_ready  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_note", note, 0);
      chk("rst_held", held_mask, 0);
      chk("rst_evv", ev_valid, 0);
      chk("rst_ovf", ev_overflow, 0);
      chk("rst_chg", note_change, 0);
      rst = 1'b0;

      step(1, 8'h15, 0, 0);
      chk("q_note", note, 12);
      chk("q_chg", note_change, 1);
      chk("q_held", held_mask, 12'h800);
`ifdef KEY_EVENT_FIFO_EN
      chk("q_ev", {ev_valid, ev_data}, 6'h3C);
`else
      chk("q_ev_off", {ev_valid, ev_data}, 6'h00);
`endif
      step(0, 8'h00, 0, 0);
      chk("q_chg_drop", note_change, 0);
      step(1, 8'h1D, 0, 0);
      chk("w_note", note, 11);
      step(1, 8'h24, 0, 0);
      chk("e_note", note, 10);
      step(1, 8'h24, 1, 0);
      chk("e_rel_note", note, 11);
      chk("e_rel_held", held_mask, 12'hC00);

      step(1, 8'h15, 0, 0);
      step(1, 8'h24, 1, 0);
      step(1, 8'h1C, 0, 0);
      step(1, 8'h1C, 1, 0);
      chk("ign_note", note, 11);
      chk("ign_held", held_mask, 12'hC00);
`ifdef KEY_EVENT_FIFO_EN
      chk("ign_ovf", ev_overflow, 0);
      chk("d0", ev_data, 5'h1C);
`endif
      step(0, 8'h00, 0, 1);
`ifdef KEY_EVENT_FIFO_EN
      chk("d1", ev_data, 5'h1B);
`endif
      step(0, 8'h00, 0, 1);
`ifdef KEY_EVENT_FIFO_EN
      chk("d2", ev_data, 5'h1A);
`endif
      step(0, 8'h00, 0, 1);
`ifdef KEY_EVENT_FIFO_EN
      chk("d3", ev_data, 5'h0A);
`endif
      step(0, 8'h00, 0, 1);
      chk("d_empty", ev_valid, 0);

      step(1, 8'h1D, 1, 0);
      step(1, 8'h15, 1, 0);
      chk("qw_rel_note", note, 0);
      step(1, 8'h5B, 0, 0);
      step(1, 8'h54, 0, 0);
      step(1, 8'h4D, 0, 0);
      chk("of_held", held_mask, 12'h007);
`ifdef KEY_EVENT_FIFO_EN
      chk("of_flag", ev_overflow, 1);
`endif
      step(1, 8'h44, 0, 1);
      chk("of_note", note, 4);
`ifdef KEY_EVENT_FIFO_EN
      chk("of_head", ev_data, 5'h0C);
`endif
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
`ifdef KEY_EVENT_FIFO_EN
      chk("of_tail", {ev_valid, ev_data}, 6'h34);
`endif
      step(0, 8'h00, 0, 1);

      rst = 1'b1;
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
      step(1, 8'h5B, 0, 1);
      step(1, 8'h54, 0, 1);
      step(1, 8'h4D, 0, 1);
      step(1, 8'h44, 0, 1);
      step(1, 8'h43, 0, 1);
      chk("stk_note", note, 5);
      chk("stk_held", held_mask, 12'h01F);
      step(1, 8'h43, 1, 1);
      step(1, 8'h44, 1, 1);
      step(1, 8'h4D, 1, 1);
      step(1, 8'h54, 1, 1);
      chk("stk_silent", note, 0);
      chk("stk_held1", held_mask, 12'h001);
      step(1, 8'h5B, 1, 1);
      chk("stk_held0", held_mask, 12'h000);
`ifdef KEY_EVENT_FIFO_EN
      chk("stk_ev", {ev_valid, ev_data}, 6'h21);
`endif
      step(0, 8'h00, 0, 1);

      step(1, 8'h15, 0, 0);
      step(1, 8'h1D, 0, 0);
      step(1, 8'h24, 0, 1);
      chk("mid_held", held_mask, 12'hE00);
      rst = 1'b1;
      step(1, 8'h2D, 0, 1);
      rst = 1'b0;
      chk("mid_out", {note, note_change, held_mask, ev_valid,
                      ev_data, ev_overflow}, 0);

      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         key_valid = $urandom_range(0, 1);
         key_code  = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                   : code_tab[$urandom_range(1, 12)];
         key_break = $urandom_range(0, 1);
         ev_ready  = ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      key_valid = 1'b0;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/note_key_scheduler.md
# note_key_scheduler

Sequences piano-key input for the note datapath. It consumes decoded PS/2 scan events and tracks which of the 12 note keys (Q through ]) are held. It resolves simultaneous key holds into a single active note by last-pressed priority, and presents that note to the tone generator. Optionally, it queues press/release events for the game/scoring logic through a valid/ready FIFO.

## Interface
Parameters:
- STACK_DEPTH, 4: number of held notes tracked in press order; range 2..12.
- FIFO_DEPTH, 4: event queue entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code/key_break valid.
- key_code  in  8  make code of the key (prefix bytes already stripped).
- key_break  in  1  1 = release, 0 = press.
- note  out  4  active note 1..12; 0 = silence.
- note_change  out  1  one-cycle pulse in the cycle `note` takes a new value.
- held_mask  out  12  bit n-1 set while note n is held.
- ev_valid  out  1  event available.
- ev_data  out  5  {press, note[3:0]}; press = 1 for key-down.
- ev_ready  in  1  consumer accepts event when high with ev_valid.
- ev_overflow  out  1  sticky flag: an event was dropped.

## Operation
- Scan-code map (note value): 15h→12, 1Dh→11, 24h→10, 2Dh→9, 2Ch→8, 35h→7, 3Ch→6, 43h→5, 44h→4, 4Dh→3, 54h→2, 5Bh→1. Any other code is ignored completely: no state change and no event.
- Press of a note already in held_mask is typematic repeat: ignored, no event.
- Press of a new note n:
  - Set held_mask[n-1] and push n to the stack top.
  - If the stack is full, discard the bottom (oldest) entry; that note stays in held_mask.
  - Generate event {1,n}.
- Release of a held note n:
  - Clear held_mask[n-1] and generate event {0,n}.
  - If n is in the stack, remove it and shift the entries above it down one place so the stack stays contiguous.
  - If n was previously discarded from the stack, the stack is unchanged.
- Release of a note not held is ignored, with no event.
- note = stack top, or 0 if the stack is empty. A discarded note is never resumed.
- Event FIFO:
  - Push each generated event.
  - Pop on ev_valid && ev_ready.
  - ev_valid = FIFO not empty; ev_data = head entry.
  - Push when full and no pop in the same cycle: the new event is dropped and ev_overflow sets, staying set until rst.
  - Push and pop in the same cycle when full: both proceed and nothing is dropped.
  - Push and pop in the same cycle when empty: the event becomes visible the next cycle. There is no bypass.
- Pointers wrap modulo FIFO_DEPTH. Use an occupancy counter of log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: note=0, note_change=0, held_mask=0, ev_valid=0, ev_data=0, ev_overflow=0; stack empty; FIFO empty.
- key_valid sampled at edge t: held_mask, the stack and note are updated at edge t. These registered outputs are visible in cycle t+1.
- note_change is high in cycle t+1 only if note differs from its cycle-t value.
- A generated event is pushed at edge t, so ev_valid is high from cycle t+1.
- A pop at edge t removes the head; the next entry, if any, is on ev_data in cycle t+1.
- The block accepts key_valid every cycle; back-to-back strobes are all processed in order.
- ev_ready is ignored while ev_valid=0.
- rst has priority over key_valid and ev_ready in the same cycle. Reset mid-operation clears all held state and queued events without generating events.

## Configuration
- KEY_EVENT_FIFO_EN defined: the event FIFO and its ports behave as described above.
- KEY_EVENT_FIFO_EN undefined: no FIFO logic is built.
  - ev_valid, ev_data and ev_overflow are tied to 0.
  - ev_ready and FIFO_DEPTH are unused.
  - note, note_change and held_mask behave identically to the defined case.

## Test plan
- Reset, then press Q (15h): note=12 and note_change pulses one cycle; held_mask=800h; ev_data={1,12}.
- Press Q, W, E, then release E: note steps 12→11→10→11; held_mask=C00h after the release; four events are queued in order.
- With STACK_DEPTH=4:
  - Press ] [ P O I (notes 1..5): note 1 is discarded from the stack; held_mask=01Fh.
  - Release I, O, P, [: note ends at 0 even though held_mask=001h.
  - Release ]: held_mask=0 and event {0,1} is generated.
- Repeat press of Q while held, release of an unheld W, and unmapped code 1Ch: no change to note or held_mask, and no events.
- ev_ready=0 with FIFO_DEPTH=4: five events leave four queued and set ev_overflow. Then, with the queue full and ev_ready=1, press in the same cycle as a pop: no further drop.
- Assert rst mid-stream with three notes held and two events queued: next cycle all outputs are 0 and ev_valid=0.
